// File: rtl/dec_ascii_tx_if.sv
// dec_ascii_tx_if -- request/byte-stream bundle for the decimal ASCII printer.
//
// Handshake semantics (single rule for both directions):
//   * A print request is taken on a rising clk edge where start=1 and the
//     printer is idle (busy=0). While busy=1, start is ignored.
//   * A byte is transferred on a rising clk edge where wr_uart=1. wr_uart is
//     only raised when tx_full=0, so tx_full acts as the inverse of "ready".
//     While tx_full=1 the pending byte is held on w_data unchanged.
//
// Signals:
//   start      master->slave  print request, level sampled each edge
//   value      master->slave  16-bit unsigned number to print
//   tx_full    master->slave  UART TX FIFO full, blocks writes
//   wr_uart    slave->master  one-byte write strobe
//   w_data     slave->master  ASCII byte, valid when wr_uart=1
//   busy       slave->master  transfer in progress
//   done_tick  slave->master  one-cycle pulse after the last byte
//   state_dbg  slave->master  current FSM state encoding, for observation

interface dec_ascii_tx_if;
    logic        start;
    logic [15:0] value;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        busy;
    logic        done_tick;
    logic [2:0]  state_dbg;

    modport master (
        output start, value, tx_full,
        input  wr_uart, w_data, busy, done_tick, state_dbg
    );

    modport slave (
        input  start, value, tx_full,
        output wr_uart, w_data, busy, done_tick, state_dbg
    );
endinterface

// File: rtl/dec_ascii_tx.sv
// dec_ascii_tx -- prints a 16-bit unsigned value as decimal ASCII into a
// UART transmit FIFO, optionally followed by CR LF.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high
//   bus    dec_ascii_tx_if.slave (start/value/tx_full in,
//          wr_uart/w_data/busy/done_tick/state_dbg out)
//
// Flow: IDLE -> CONV (16 double-dabble steps) -> SEND (1..5 digits)
//       -> [CR -> LF] -> DONE (one cycle) -> IDLE.

module dec_ascii_tx #(
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    dec_ascii_tx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CONV = 3'd1,
        SEND = 3'd2,
        CR   = 3'd3,
        LF   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] bin;    // captured value; shifted out MSB-first during CONV
    logic [19:0] bcd;    // five BCD digits; in SEND the next digit sits in [19:16]
    logic [3:0]  cnt;    // CONV step counter, 0..15
    logic [2:0]  ndig;   // digits still to send

    // One double-dabble step: add 3 to every digit >= 5, then shift
    // {bcd, bin} left by one.
    function automatic logic [35:0] dabble_step(input logic [19:0] b,
                                                input logic [15:0] s);
        logic [19:0] adj;
        for (int i = 0; i < 5; i++) begin
            adj[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3
                                                  : b[4*i +: 4];
        end
        return {adj[18:0], s, 1'b0};
    endfunction

    // Number of significant digits; zero still prints one digit.
    function automatic logic [2:0] digit_count(input logic [19:0] b);
        logic [2:0] n;
        n = 3'd1;
        for (int i = 1; i < 5; i++) begin
            if (b[4*i +: 4] != 4'd0) n = 3'(i + 1);
        end
        return n;
    endfunction

    logic [35:0] step;
    logic [19:0] bcd_next;
    logic [2:0]  nd_next;
    logic [4:0]  shamt;
    logic [19:0] bcd_aligned;

    // On the final CONV step the result is left-aligned so the first
    // significant digit lands in [19:16]; leading zeros are thereby
    // dropped without spending SEND cycles on them.
    always_comb begin
        step        = dabble_step(bcd, bin);
        bcd_next    = step[35:16];
        nd_next     = digit_count(bcd_next);
        shamt       = {3'd5 - nd_next, 2'b00};
        bcd_aligned = bcd_next << shamt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bin   <= 16'd0;
            bcd   <= 20'd0;
            cnt   <= 4'd0;
            ndig  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin   <= bus.value;
                        bcd   <= 20'd0;
                        cnt   <= 4'd0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    cnt <= cnt + 4'd1;
                    bin <= step[15:0];
                    if (cnt == 4'd15) begin
                        bcd   <= bcd_aligned;
                        ndig  <= nd_next;
                        state <= SEND;
                    end else begin
                        bcd <= bcd_next;
                    end
                end
                SEND: begin
                    if (!bus.tx_full) begin
                        bcd  <= bcd << 4;
                        ndig <= ndig - 3'd1;
                        if (ndig == 3'd1) state <= SEND_CRLF ? CR : DONE;
                    end
                end
                CR: begin
                    if (!bus.tx_full) state <= LF;
                end
                LF: begin
                    if (!bus.tx_full) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte path: w_data follows the pending byte even while stalled, so it
    // is stable across any tx_full stall; wr_uart is gated by tx_full.
    logic       wr;
    logic [7:0] data;

    always_comb begin
        wr   = 1'b0;
        data = 8'h00;
        case (state)
            SEND: begin
                wr   = !bus.tx_full;
                data = {4'h3, bcd[19:16]};
            end
            CR: begin
                wr   = !bus.tx_full;
                data = 8'h0D;
            end
            LF: begin
                wr   = !bus.tx_full;
                data = 8'h0A;
            end
            default: begin
                wr   = 1'b0;
                data = 8'h00;
            end
        endcase
    end

    assign bus.wr_uart   = wr;
    assign bus.w_data    = data;
    assign bus.busy      = (state != IDLE);
    assign bus.done_tick = (state == DONE);
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_dec_ascii_tx.sv
// tb_dec_ascii_tx -- bench for dec_ascii_tx. Two instances (with and without
// CR LF) receive identical stimulus; each has its own expected-byte queue.
// Expected streams come from printing the value in decimal with integer
// division; done_tick is queued as a marker after the last byte.

module tb_dec_ascii_tx;

    localparam int W = 9;
    localparam logic [W-1:0] DONE_MARK = 9'h100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dec_ascii_tx_if bus1();
    dec_ascii_tx_if bus0();

    dec_ascii_tx #(.SEND_CRLF(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    dec_ascii_tx #(.SEND_CRLF(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp0_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: decimal digits by repeated division, MSB first.
    function automatic void push_expected(input logic [15:0] v);
        int n;
        int d[$];
        n = int'(v);
        do begin
            d.push_front(n % 10);
            n = n / 10;
        end while (n > 0);
        foreach (d[i]) begin
            exp_q.push_back(W'(8'h30 + d[i]));
            exp0_q.push_back(W'(8'h30 + d[i]));
        end
        exp_q.push_back(W'(8'h0D));
        exp_q.push_back(W'(8'h0A));
        exp_q.push_back(DONE_MARK);
        exp0_q.push_back(DONE_MARK);
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (bus1.wr_uart) begin
                check("crlf_wr_while_full", 32'(bus1.tx_full), 32'd0);
                if (exp_q.size() == 0) fail_now($sformatf("crlf_unexpected_byte got %h required none", bus1.w_data));
                else check("crlf_byte", 32'({1'b0, bus1.w_data}), 32'(exp_q.pop_front()));
            end
            if (bus1.done_tick) begin
                if (exp_q.size() == 0) fail_now("crlf_unexpected_done got done required none");
                else check("crlf_done_order", 32'(DONE_MARK), 32'(exp_q.pop_front()));
            end
            if (bus0.wr_uart) begin
                check("nocrlf_wr_while_full", 32'(bus0.tx_full), 32'd0);
                if (exp0_q.size() == 0) fail_now($sformatf("nocrlf_unexpected_byte got %h required none", bus0.w_data));
                else check("nocrlf_byte", 32'({1'b0, bus0.w_data}), 32'(exp0_q.pop_front()));
            end
            if (bus0.done_tick) begin
                if (exp0_q.size() == 0) fail_now("nocrlf_unexpected_done got done required none");
                else check("nocrlf_done_order", 32'(DONE_MARK), 32'(exp0_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_start(input logic s, input logic [15:0] v);
        bus1.start = s;
        bus1.value = v;
        bus0.start = s;
        bus0.value = v;
    endtask

    task automatic set_full(input logic f);
        bus1.tx_full = f;
        bus0.tx_full = f;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus1.busy || bus0.busy) begin
            @(posedge clk);
            #1;
            n++;
            if (n > budget) begin
                fail_now("idle_timeout");
                break;
            end
        end
    endtask

    task automatic issue(input logic [15:0] v);
        wait_idle(2000);
        push_expected(v);
        set_start(1'b1, v);
        @(posedge clk);
        #1;
        set_start(1'b0, 16'd0);
        check("busy_after_accept", 32'(bus1.busy), 32'd1);
    endtask

    // Waits (bounded) until the CRLF instance has presented k strobes.
    task automatic wait_strobes(input int k);
        int s;
        int n;
        s = 0;
        n = 0;
        while (s < k && n < 200) begin
            @(negedge clk);
            n++;
            if (bus1.wr_uart) s++;
        end
        if (s < k) fail_now("strobe_timeout");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [15:0] v;

        reset = 1'b1;
        set_start(1'b0, 16'd0);
        set_full(1'b0);
        #6;
        check("rst_wr_uart", 32'(bus1.wr_uart), 32'd0);
        check("rst_busy", 32'(bus1.busy), 32'd0);
        check("rst_done", 32'(bus1.done_tick), 32'd0);
        check("rst_w_data", 32'(bus1.w_data), 32'd0);
        check("rst_state", 32'(bus1.state_dbg), 32'd0);
        check("rst_busy_nocrlf", 32'(bus0.busy), 32'd0);
        reset = 1'b0;

        // Value 0, first accepted edge after reset, latency to first strobe.
        push_expected(16'd0);
        set_start(1'b1, 16'd0);
        @(posedge clk);
        #1;
        set_start(1'b0, 16'd0);
        check("first_accept_busy", 32'(bus1.busy), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.wr_uart && n < 40);
        check("first_strobe_latency", 32'(n), 32'd17);
        wait_idle(100);
        check("busy_low_after", 32'(bus1.busy), 32'd0);

        issue(16'd233);
        issue(16'd65535);

        // Stall while the second digit (0x35) is presented.
        issue(16'd1597);
        wait_strobes(1);
        @(posedge clk);
        #1;
        set_full(1'b1);
        repeat (5) begin
            @(negedge clk);
            check("stall_wr_uart", 32'(bus1.wr_uart), 32'd0);
            check("stall_w_data", 32'(bus1.w_data), 32'h35);
            check("stall_w_data_nocrlf", 32'(bus0.w_data), 32'h35);
        end
        @(posedge clk);
        #1;
        set_full(1'b0);

        // Start during CONV is ignored.
        issue(16'd89);
        repeat (4) @(posedge clk);
        #1;
        set_start(1'b1, 16'd144);
        @(posedge clk);
        #1;
        set_start(1'b0, 16'd0);
        wait_idle(200);

        // Reset in the middle of SEND abandons the transfer.
        issue(16'd4181);
        wait_strobes(2);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_wr_uart", 32'(bus1.wr_uart), 32'd0);
        check("rst_mid_busy", 32'(bus1.busy), 32'd0);
        check("rst_mid_busy_nocrlf", 32'(bus0.busy), 32'd0);
        exp_q.delete();
        exp0_q.delete();
        @(posedge clk);
        #3;
        reset = 1'b0;
        issue(16'd7);

        // start held high: back-to-back transfers, second uses the new value.
        wait_idle(200);
        push_expected(16'd305);
        push_expected(16'd42);
        set_start(1'b1, 16'd305);
        @(posedge clk);
        #1;
        set_start(1'b1, 16'd42);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus1.done_tick && n < 100);
        @(posedge clk);
        #1;
        check("b2b_idle_gap", 32'(bus1.busy), 32'd0);
        @(posedge clk);
        #1;
        check("b2b_reaccept", 32'(bus1.busy), 32'd1);
        set_start(1'b0, 16'd0);
        wait_idle(200);

        // Randomized values with random FIFO back-pressure.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 16'($urandom_range(0, 9));
                1:       v = 16'($urandom_range(10, 999));
                default: v = 16'($urandom_range(0, 65535));
            endcase
            issue(v);
            n = 0;
            while ((bus1.busy || bus0.busy) && n < 2000) begin
                @(posedge clk);
                #1;
                set_full($urandom_range(0, 3) == 0);
                n++;
            end
            set_full(1'b0);
        end

        wait_idle(200);
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty_crlf", 32'(exp_q.size()), 32'd0);
        check("queue_empty_nocrlf", 32'(exp0_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
